// File: rtl/traffic_input_cond_if.sv
// Signal bundle between the traffic input-conditioning stage and its neighbours.
// The slave modport is the conditioning block; the master side drives the sensor and clear.
interface traffic_input_cond_if;
   logic s_raw;
   logic clear;
   logic tick_1s;
   logic s_db;
   logic s_rise;
   logic s_req;

   modport master (
      output s_raw,
      output clear,
      input  tick_1s,
      input  s_db,
      input  s_rise,
      input  s_req
   );

   modport slave (
      input  s_raw,
      input  clear,
      output tick_1s,
      output s_db,
      output s_rise,
      output s_req
   );
endinterface

// File: rtl/traffic_input_cond.sv
// Input conditioning for the traffic-light controller: 1 s tick, sensor sync/debounce, request.
// Optional post-vehicle request hold is compiled in with `define SENSOR_HOLD_EN.
module traffic_input_cond #(
   parameter int TICK_DIV   = 50000000,
   parameter int DB_CYCLES  = 500000,
   parameter int HOLD_TICKS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   traffic_input_cond_if.slave  bus
);

   localparam int CW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          s_db_q, s_db_d;
   logic          s_rise_q, s_rise_d;

   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (bus.clear) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(TICK_DIV - 1)) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Any cycle where the synchronized input agrees with s_db restarts the count.
   always_comb begin
      s_db_d   = s_db_q;
      db_cnt_d = db_cnt_q + DW'(1);
      if (sync2_q == s_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
         s_db_d   = sync2_q;
         db_cnt_d = '0;
      end
      s_rise_d = s_db_d & ~s_db_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         db_cnt_q <= '0;
         s_db_q   <= 1'b0;
         s_rise_q <= 1'b0;
      end else begin
         sync1_q  <= bus.s_raw;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         db_cnt_q <= db_cnt_d;
         s_db_q   <= s_db_d;
         s_rise_q <= s_rise_d;
      end
   end

`ifdef SENSOR_HOLD_EN
   localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

   logic [HW-1:0] hold_cnt_q, hold_cnt_d;

   // Falling s_db loads the hold; the load takes priority over a coincident tick.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (s_db_q && !s_db_d) begin
         hold_cnt_d = HW'(HOLD_TICKS);
      end else if (!s_db_q && s_db_d) begin
         hold_cnt_d = '0;
      end else if (tick_q && (hold_cnt_q != '0)) begin
         hold_cnt_d = hold_cnt_q - HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign bus.s_req = s_db_q | (hold_cnt_q != '0);
`else
   assign bus.s_req = s_db_q;
`endif

   assign bus.tick_1s = tick_q;
   assign bus.s_db    = s_db_q;
   assign bus.s_rise  = s_rise_q;

endmodule
